// File: rtl/turn_signal_controller.sv
// Left/right/hazard indicator sequencer with a clock-enable style blink timebase.
// Optional macro TURN_LATCH_EN: a started turn completes MIN_BLINKS full blinks after release.
module turn_signal_controller #(
    parameter int HALF_PERIOD = 50_000_000,
    parameter int MIN_BLINKS  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_now,
    input  logic [3:0] state,
    input  logic [3:0] answer,
    input  logic       hazard_req,
    output logic       left_led,
    output logic       right_led,
    output logic       busy
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [3:0]    BLINK_MAX = 4'(MIN_BLINKS);

    typedef enum logic [2:0] {
        S_OFF,
        S_IDLE,
        S_LEFT,
        S_RIGHT,
        S_HAZ
    } fsm_t;

    fsm_t          state_reg;
    fsm_t          state_next;
    fsm_t          sel;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          phase_reg;
    logic          phase_next;
    logic [3:0]    blink_cnt_reg;
    logic [3:0]    blink_cnt_next;
    logic          powered;
    logic          drive_active;
    logic          next_blinking;
    logic          entering;
`ifdef TURN_LATCH_EN
    logic          blink_done;
`endif

    // Request arbitration; S_IDLE doubles as "no request selected".
    always_comb begin
        powered      = power_now && (state != 4'b1000);
        drive_active = (state == 4'b0010) || (state == 4'b0100);
        sel          = S_IDLE;
        if (hazard_req || (drive_active && answer[3] && answer[2])) begin
            sel = S_HAZ;
        end else if (drive_active && answer[3]) begin
            sel = S_LEFT;
        end else if (drive_active && answer[2]) begin
            sel = S_RIGHT;
        end
    end

`ifdef TURN_LATCH_EN
    // Last cycle of the final off half-period: the turn has completed its blinks.
    assign blink_done = (blink_cnt_reg == BLINK_MAX) && !phase_reg && (cnt_reg == CNT_LAST);
`endif

    always_comb begin
        state_next = state_reg;
        if (!powered) begin
            state_next = S_OFF;
        end else begin
            case (state_reg)
                S_OFF:   state_next = S_IDLE;
                S_IDLE:  state_next = sel;
                default: begin
                    if (sel != S_IDLE) begin
                        state_next = sel;
                    end else if ((state_reg == S_HAZ) || !drive_active) begin
                        state_next = S_IDLE;
                    end else begin
`ifdef TURN_LATCH_EN
                        state_next = blink_done ? S_IDLE : state_reg;
`else
                        state_next = S_IDLE;
`endif
                    end
                end
            endcase
        end
    end

    always_comb begin
        next_blinking  = (state_next == S_LEFT) || (state_next == S_RIGHT) || (state_next == S_HAZ);
        entering       = next_blinking && (state_next != state_reg);
        cnt_next       = cnt_reg;
        phase_next     = phase_reg;
        blink_cnt_next = blink_cnt_reg;
        if (!next_blinking) begin
            cnt_next       = '0;
            phase_next     = 1'b0;
            blink_cnt_next = '0;
        end else if (entering) begin
            // Every entry, including a direct switch between blink states, starts lit.
            cnt_next       = '0;
            phase_next     = 1'b1;
            blink_cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            phase_next = ~phase_reg;
            if (phase_reg && (blink_cnt_reg < BLINK_MAX)) begin
                blink_cnt_next = blink_cnt_reg + 4'd1;
            end
        end else begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_OFF;
            cnt_reg       <= '0;
            phase_reg     <= 1'b0;
            blink_cnt_reg <= '0;
            left_led      <= 1'b0;
            right_led     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            phase_reg     <= phase_next;
            blink_cnt_reg <= blink_cnt_next;
            left_led      <= phase_next && ((state_next == S_LEFT) || (state_next == S_HAZ));
            right_led     <= phase_next && ((state_next == S_RIGHT) || (state_next == S_HAZ));
            busy          <= next_blinking;
        end
    end

endmodule

// File: tb/tb_turn_signal_controller.sv
// Bench for turn_signal_controller: vector table, random run against a cycle-count model,
// and directed async-reset / latch / power-drop sequences.
module tb_turn_signal_controller;

    localparam int HP = 4;
    localparam int MB = 2;

    localparam int M_OFF   = 0;
    localparam int M_IDLE  = 1;
    localparam int M_LEFT  = 2;
    localparam int M_RIGHT = 3;
    localparam int M_HAZ   = 4;
    localparam int M_NONE  = -1;

    logic       clk = 1'b0;
    logic       rst;
    logic       power_now;
    logic [3:0] state;
    logic [3:0] answer;
    logic       hazard_req;
    logic       left_led;
    logic       right_led;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int m_mode;
    int m_t;

    typedef struct {
        logic       p;
        logic [3:0] st;
        logic [3:0] ans;
        logic       hz;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl[28];

    always #5 clk = ~clk;

    turn_signal_controller #(
        .HALF_PERIOD(HP),
        .MIN_BLINKS (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .power_now (power_now),
        .state     (state),
        .answer    (answer),
        .hazard_req(hazard_req),
        .left_led  (left_led),
        .right_led (right_led),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [2:0] exp);
        n_cmp++;
        if ({left_led, right_led, busy} !== exp) begin
            n_bad++;
            $display("FAIL %s: {left,right,busy} got %b expected %b at %0t", name,
                     {left_led, right_led, busy}, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = M_OFF;
        m_t    = 0;
    endfunction

    // Model: current mode plus cycles elapsed since entering it.
    function automatic void model_step();
        bit powered;
        bit act;
        int sel;
        int nm;
        powered = power_now && (state != 4'b1000);
        act     = (state == 4'b0010) || (state == 4'b0100);
        if (hazard_req || (act && answer[3] && answer[2])) sel = M_HAZ;
        else if (act && answer[3]) sel = M_LEFT;
        else if (act && answer[2]) sel = M_RIGHT;
        else sel = M_NONE;
        if (!powered) nm = M_OFF;
        else if (m_mode == M_OFF) nm = M_IDLE;
        else if (m_mode == M_IDLE) nm = (sel == M_NONE) ? M_IDLE : sel;
        else if (sel != M_NONE) nm = sel;
        else if (m_mode == M_HAZ || !act) nm = M_IDLE;
        else begin
`ifdef TURN_LATCH_EN
            nm = (m_t + 1 >= 2 * HP * MB) ? M_IDLE : m_mode;
`else
            nm = M_IDLE;
`endif
        end
        if (nm >= M_LEFT) m_t = (nm != m_mode) ? 0 : m_t + 1;
        else m_t = 0;
        m_mode = nm;
    endfunction

    function automatic logic [2:0] model_exp();
        bit on;
        on = (m_t % (2 * HP)) < HP;
        return {on && (m_mode == M_LEFT || m_mode == M_HAZ),
                on && (m_mode == M_RIGHT || m_mode == M_HAZ),
                m_mode >= M_LEFT};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_vec(input int i, input logic p, input logic [3:0] st, input logic [3:0] ans,
                           input logic hz, input logic [2:0] exp);
        tbl[i] = '{p, st, ans, hz, exp};
    endtask

    initial begin
        int busy_cnt;
        int left_cnt;
        int exp_busy;
        int exp_left;

        // {left,right,busy} after each edge
        set_vec(0, 1'b1, 4'b0100, 4'b0000, 1'b0, 3'b000);
        set_vec(1, 1'b1, 4'b0100, 4'b0000, 1'b0, 3'b000);
        for (int i = 2; i <= 11; i++)
            set_vec(i, 1'b1, 4'b0100, 4'b1000, 1'b0, (i >= 6 && i <= 9) ? 3'b001 : 3'b101);
        for (int i = 12; i <= 16; i++)
            set_vec(i, 1'b1, 4'b0100, 4'b0100, 1'b0, (i == 16) ? 3'b001 : 3'b011);
        set_vec(17, 1'b1, 4'b0001, 4'b1100, 1'b0, 3'b000);
        set_vec(18, 1'b1, 4'b0001, 4'b1100, 1'b0, 3'b000);
        for (int i = 19; i <= 23; i++)
            set_vec(i, 1'b1, 4'b0001, 4'b1100, 1'b1, (i == 23) ? 3'b001 : 3'b111);
        set_vec(24, 1'b0, 4'b0001, 4'b1100, 1'b1, 3'b000);
        set_vec(25, 1'b1, 4'b0001, 4'b1100, 1'b1, 3'b000);
        set_vec(26, 1'b1, 4'b0001, 4'b1100, 1'b1, 3'b111);
        set_vec(27, 1'b1, 4'b1000, 4'b1100, 1'b1, 3'b000);

        rst        = 1'b0;
        power_now  = 1'b1;
        state      = 4'b0100;
        answer     = 4'b0000;
        hazard_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", 3'b000);

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            rst        = 1'b1;
            power_now  = tbl[i].p;
            state      = tbl[i].st;
            answer     = tbl[i].ans;
            hazard_req = tbl[i].hz;
            tick();
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Random run against the model, starting from an async reset.
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #2;
        rst = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if ($urandom_range(5) == 0) begin
                power_now  = ($urandom_range(15) != 0);
                state      = 4'b0001 << $urandom_range(3);
                answer     = 4'($urandom);
                hazard_req = ($urandom_range(7) == 0);
            end
            tick();
            check("rand", model_exp());
        end

        // Async reset mid-blink takes effect without a clock edge.
        @(negedge clk);
        power_now = 1'b1; state = 4'b0100; answer = 4'b0000; hazard_req = 1'b0;
        tick();
        tick();
        @(negedge clk);
        answer = 4'b1000;
        tick();
        tick();
        check("pre_rst_on", 3'b101);
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_rst", 3'b000);
        #1;
        rst = 1'b1;
        tick();
        check("rst_off_to_idle", 3'b000);
        tick();
        check("rst_first_blink", 3'b101);

        // One-cycle left request: latched turn vs immediate release.
        @(negedge clk);
        power_now = 1'b0; answer = 4'b0000;
        tick();
        @(negedge clk);
        power_now = 1'b1;
        tick();
        check("idle_before_pulse", 3'b000);
        @(negedge clk);
        answer = 4'b1000;
        tick();
        check("pulse_entry", 3'b101);
        busy_cnt = busy ? 1 : 0;
        left_cnt = left_led ? 1 : 0;
        @(negedge clk);
        answer = 4'b0000;
        for (int k = 0; k < 40; k++) begin
            tick();
            check("pulse_track", model_exp());
            busy_cnt += busy ? 1 : 0;
            left_cnt += left_led ? 1 : 0;
            @(negedge clk);
        end
`ifdef TURN_LATCH_EN
        exp_busy = 2 * HP * MB;
        exp_left = HP * MB;
`else
        exp_busy = 1;
        exp_left = 1;
`endif
        check_int("pulse_busy_cycles", busy_cnt, exp_busy);
        check_int("pulse_left_cycles", left_cnt, exp_left);

        // Same pulse, power dropped at cycle 5: everything dark on the next edge.
        answer = 4'b1000;
        tick();
        check("pwr_entry", 3'b101);
        @(negedge clk);
        answer = 4'b0000;
        for (int k = 2; k <= 4; k++) begin
            tick();
            check("pwr_hold", model_exp());
            @(negedge clk);
        end
        power_now = 1'b0;
        tick();
        check("pwr_drop", 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
